// File: rtl/ser2par_pkg.sv
// Shared helpers for the serial-to-parallel packer: counter sizing and beat-to-lane mapping.
package ser2par_pkg;

  // Counter must hold 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned lane_idx(input int unsigned k, input int unsigned num,
                                           input bit first_msb);
    return first_msb ? (num - 1 - k) : k;
  endfunction

endpackage

// File: rtl/s2p_out_slot.sv
// Registered valid/ready holding stage; payload is frozen while valid and not accepted.
module s2p_out_slot #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/ser2par_stream.sv
// Packs IN_NUM beats into one word with in_last flush, lane keep mask and selectable lane order.
module ser2par_stream
  import ser2par_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned IN_NUM    = 4,
  parameter int unsigned OUT_WIDTH = IN_NUM * IN_WIDTH,
  parameter int unsigned FIRST_MSB = 1,
  parameter int unsigned CNT_W     = cnt_w(IN_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [IN_NUM-1:0]    out_keep,
  output logic                 out_last
);

  localparam int unsigned SlotW = OUT_WIDTH + IN_NUM + 1;

  logic [OUT_WIDTH-1:0] acc_data_q, acc_data_d;
  logic [IN_NUM-1:0]    acc_keep_q, acc_keep_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 acc_last_q, acc_last_d;
  logic                 acc_full_q, acc_full_d;

  logic [CNT_W-1:0]     lane;
  logic [OUT_WIDTH-1:0] beat_data;
  logic [IN_NUM-1:0]    beat_keep;
  logic                 accept, complete, slot_free, load_valid;
  logic [SlotW-1:0]     load_word, slot_word;

  assign in_ready = !acc_full_q;
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((cnt_q == CNT_W'(IN_NUM - 1)) || in_last);

  // Accumulator contents with the current beat merged in.
  always_comb begin
    lane      = CNT_W'(lane_idx(32'(cnt_q), IN_NUM, FIRST_MSB != 0));
    beat_data = acc_data_q;
    beat_keep = acc_keep_q;
    for (int i = 0; i < IN_NUM; i++) begin
      if (lane == CNT_W'(i)) begin
        beat_data[i*IN_WIDTH +: IN_WIDTH] = in_data;
        beat_keep[i]                      = 1'b1;
      end
    end
  end

  // A parked full word takes precedence; it and a new beat are mutually exclusive.
  assign load_valid = acc_full_q || complete;
  assign load_word  = acc_full_q ? {acc_last_q, acc_keep_q, acc_data_q}
                                 : {in_last, beat_keep, beat_data};

  always_comb begin
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    cnt_d      = cnt_q;
    acc_last_d = acc_last_q;
    acc_full_d = acc_full_q;
    if (clear) begin
      acc_data_d = '0;
      acc_keep_d = '0;
      cnt_d      = '0;
      acc_last_d = 1'b0;
      acc_full_d = 1'b0;
    end else if (acc_full_q) begin
      if (slot_free) begin
        acc_data_d = '0;
        acc_keep_d = '0;
        cnt_d      = '0;
        acc_last_d = 1'b0;
        acc_full_d = 1'b0;
      end
    end else if (accept) begin
      if (complete && slot_free) begin
        acc_data_d = '0;
        acc_keep_d = '0;
        cnt_d      = '0;
        acc_last_d = 1'b0;
      end else if (complete) begin
        acc_data_d = beat_data;
        acc_keep_d = beat_keep;
        acc_last_d = in_last;
        acc_full_d = 1'b1;
      end else begin
        acc_data_d = beat_data;
        acc_keep_d = beat_keep;
        cnt_d      = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_data_q <= '0;
      acc_keep_q <= '0;
      cnt_q      <= '0;
      acc_last_q <= 1'b0;
      acc_full_q <= 1'b0;
    end else begin
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
      cnt_q      <= cnt_d;
      acc_last_q <= acc_last_d;
      acc_full_q <= acc_full_d;
    end
  end

  s2p_out_slot #(
    .WIDTH(SlotW)
  ) u_out_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (load_valid),
    .in_ready (slot_free),
    .in_data  (load_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (slot_word)
  );

  assign out_data = slot_word[OUT_WIDTH-1:0];
  assign out_keep = slot_word[OUT_WIDTH +: IN_NUM];
  assign out_last = slot_word[SlotW-1];

endmodule

// File: tb/tb_ser2par_stream.sv
// Scoreboard bench: two packers (MSB-first and LSB-first lane order) share one input stream.
module tb_ser2par_stream;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_last_a, out_last_b;
  logic [31:0] out_data_a, out_data_b;
  logic [3:0]  out_keep_a, out_keep_b;

  always #5 clk = ~clk;

  ser2par_stream #(.IN_WIDTH(8), .IN_NUM(4), .FIRST_MSB(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_keep(out_keep_a), .out_last(out_last_a)
  );

  ser2par_stream #(.IN_WIDTH(8), .IN_NUM(4), .FIRST_MSB(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_keep(out_keep_b), .out_last(out_last_b)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected words as {last, keep, data}.
  logic [36:0] sb_a[$];
  logic [36:0] sb_b[$];
  logic [31:0] m_da, m_db;
  logic [3:0]  m_ka, m_kb;
  int          m_cnt;

  task automatic model_reset();
    m_da = '0; m_db = '0; m_ka = '0; m_kb = '0; m_cnt = 0;
  endtask

  task automatic flush_expect();
    sb_a.delete();
    sb_b.delete();
    model_reset();
  endtask

  // Present one beat from posedge+1 until accepted; returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [7:0] d, input logic last, output int stalls);
    int n;
    in_valid = 1'b1; in_data = d; in_last = last; stalls = 0;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready_a) break;
      stalls++;
    end
    if (n == 50) begin
      check_eq("accept_timeout", {63'd0, in_ready_a}, 64'd1);
    end else begin
      m_da[(3 - m_cnt)*8 +: 8] = d;
      m_ka[3 - m_cnt]          = 1'b1;
      m_db[m_cnt*8 +: 8]       = d;
      m_kb[m_cnt]              = 1'b1;
      m_cnt++;
      if (m_cnt == 4 || last) begin
        sb_a.push_back({last, m_ka, m_da});
        sb_b.push_back({last, m_kb, m_db});
        model_reset();
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare handshaken words against the scoreboard and check slot stability.
  logic        held_a;
  logic [36:0] held_w;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_a <= 1'b0;
    end else begin
      if (out_valid_a && out_ready) begin
        if (sb_a.size() == 0) check_eq("unexpected_a", {27'd0, out_last_a, out_keep_a, out_data_a}, 64'd0);
        else check_eq("word_a", {27'd0, out_last_a, out_keep_a, out_data_a}, {27'd0, sb_a.pop_front()});
      end
      if (out_valid_b && out_ready) begin
        if (sb_b.size() == 0) check_eq("unexpected_b", {27'd0, out_last_b, out_keep_b, out_data_b}, 64'd0);
        else check_eq("word_b", {27'd0, out_last_b, out_keep_b, out_data_b}, {27'd0, sb_b.pop_front()});
      end
      if (out_valid_a && !out_ready) begin
        if (held_a) check_eq("hold_a", {27'd0, out_last_a, out_keep_a, out_data_a}, {27'd0, held_w});
        held_a <= 1'b1;
        held_w <= {out_last_a, out_keep_a, out_data_a};
      end else begin
        held_a <= 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  logic [7:0] t1[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  int st;

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #1;
    check_eq("rst_valid", {63'd0, out_valid_a}, 64'd0);
    check_eq("rst_data", {32'd0, out_data_a}, 64'd0);
    check_eq("rst_keep_last", {59'd0, out_keep_a, out_last_a}, 64'd0);
    check_eq("rst_ready", {62'd0, in_ready_a, in_ready_b}, 64'd3);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Sustained throughput: no stalls with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_beat(t1[i], 1'b0, st);
      check_eq("tput_stall", 64'(st), 64'd0);
      if (i == 3) begin
        check_eq("lat_valid", {62'd0, out_valid_a, out_valid_b}, 64'd3);
        check_eq("full_msb", {27'd0, out_last_a, out_keep_a, out_data_a}, {27'd0, 1'b0, 4'hf, 32'h11223344});
        check_eq("full_lsb", {27'd0, out_last_b, out_keep_b, out_data_b}, {27'd0, 1'b0, 4'hf, 32'h44332211});
      end
    end
    idle(3);

    // Short packet flush, then next word must restart at the first lane.
    send_beat(8'hAA, 1'b0, st);
    send_beat(8'hBB, 1'b1, st);
    check_eq("short_msb", {27'd0, out_last_a, out_keep_a, out_data_a}, {27'd0, 1'b1, 4'b1100, 32'hAABB0000});
    check_eq("short_lsb", {27'd0, out_last_b, out_keep_b, out_data_b}, {27'd0, 1'b1, 4'b0011, 32'h0000BBAA});
    for (int i = 0; i < 4; i++) send_beat(8'hC1 + 8'(i), 1'b0, st);
    idle(3);

    // Backpressure: second word parks in the accumulator and blocks input.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(8'h01 + 8'(i), 1'b0, st);
    check_eq("bp_ready_low", {63'd0, in_ready_a}, 64'd0);
    check_eq("bp_first", {32'd0, out_data_a}, 64'h01020304);
    idle(2);
    check_eq("bp_ready_hold", {63'd0, in_ready_a}, 64'd0);
    out_ready = 1'b1;
    idle(1);
    check_eq("bp_second", {31'd0, out_valid_a, out_data_a}, {31'd0, 1'b1, 32'h05060708});
    check_eq("bp_ready_back", {63'd0, in_ready_a}, 64'd1);
    idle(1);
    check_eq("bp_drained", {63'd0, out_valid_a}, 64'd0);
    idle(2);

    // Synchronous clear drops the slot, the partial word and the beat presented with it.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(8'h91 + 8'(i), 1'b0, st);
    send_beat(8'hA1, 1'b0, st);
    send_beat(8'hA2, 1'b0, st);
    check_eq("clr_pre_valid", {63'd0, out_valid_a}, 64'd1);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    flush_expect();
    check_eq("clr_valid", {62'd0, out_valid_a, out_valid_b}, 64'd0);
    check_eq("clr_ready", {63'd0, in_ready_a}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(8'h51 + 8'(i), 1'b0, st);
    check_eq("clr_next", {27'd0, out_last_a, out_keep_a, out_data_a}, {27'd0, 1'b0, 4'hf, 32'h51525354});
    idle(3);

    // Asynchronous reset mid-word with a word held in the slot.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(8'h61 + 8'(i), 1'b0, st);
    for (int i = 0; i < 3; i++) send_beat(8'h71 + 8'(i), 1'b0, st);
    rst_n = 1'b0;
    #1;
    flush_expect();
    check_eq("arst_valid", {62'd0, out_valid_a, out_valid_b}, 64'd0);
    check_eq("arst_data", {out_data_a, out_data_b}, 64'd0);
    check_eq("arst_keep_last", {54'd0, out_keep_a, out_keep_b, out_last_a, out_last_b}, 64'd0);
    check_eq("arst_ready", {62'd0, in_ready_a, in_ready_b}, 64'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(8'h81 + 8'(i), 1'b0, st);
    check_eq("arst_next", {27'd0, out_last_a, out_keep_a, out_data_a}, {27'd0, 1'b0, 4'hf, 32'h81828384});
    idle(4);

    check_eq("sb_empty", 64'(sb_a.size() + sb_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
